// File: rtl/match_pkg.sv
// Shared encodings for the match-stick turn controller: FSM states, display
// status codes and player digits.
package match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_COMMIT,
        ST_ERROR,
        ST_WAIT_REL,
        ST_OVER
    } state_t;

    localparam logic [1:0] STAT_NORMAL  = 2'b00;
    localparam logic [1:0] STAT_INVALID = 2'b01;
    localparam logic [1:0] STAT_OVER    = 2'b10;

    localparam logic [3:0] P1 = 4'd1;
    localparam logic [3:0] P2 = 4'd2;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count filter for one active-low button.
// o_level is 1 while the button is considered pressed.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_level
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    // The counter tracks how many consecutive synchronized samples disagree
    // with the current level; any agreeing sample restarts the run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], ~i_btn_n};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/match_turn_controller.sv
// Match-stick game sequencer: debounced move/restart buttons, move validation,
// stick total, player alternation and display status arbitration.
module match_turn_controller
    import match_pkg::*;
#(
    parameter int START_TOTAL = 100,
    parameter int MAX_TAKE    = 10,
    parameter int TOTAL_W     = 7,
    parameter int DB_CYCLES   = 4,
    parameter int ERR_HOLD    = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_btn_n,
    input  logic [3:0]         i_take,
    output logic [TOTAL_W-1:0] o_total,
    output logic [3:0]         o_player_id,
    output logic [1:0]         o_status,
    output logic               o_move_strobe
);

    localparam int ERR_W  = $clog2(ERR_HOLD + 1);
    localparam int SETTLE = DB_CYCLES + 3;
    localparam int SET_W  = $clog2(SETTLE + 1);
    localparam logic [3:0] MAX_T = 4'(MAX_TAKE);

    logic [1:0]       w_lvl;
    logic [1:0]       r_prev;
    logic [1:0]       r_arm;
    logic [SET_W-1:0] r_settle;
    logic [1:0]       w_edge;
    logic             w_mv_edge;
    logic             w_rs_edge;

    for (genvar g = 0; g < 2; g++) begin : g_db
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_btn_n (i_btn_n[g]),
            .o_level (w_lvl[g])
        );
    end

    // A button only becomes armed once it is seen released after the
    // synchronizer and filter have settled, so a button held through reset
    // must be let go and pressed again before it produces an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev   <= 2'b00;
            r_arm    <= 2'b00;
            r_settle <= '0;
        end else begin
            r_prev <= w_lvl;
            if (r_settle != SET_W'(SETTLE))
                r_settle <= r_settle + SET_W'(1);
            r_arm <= r_arm | ({2{r_settle == SET_W'(SETTLE)}} & ~w_lvl);
        end
    end

    assign w_edge    = r_arm & w_lvl & ~r_prev;
    assign w_mv_edge = w_edge[0];
    assign w_rs_edge = w_edge[1];

    state_t             r_state, w_state_nx;
    logic [3:0]         r_take, w_take_nx;
    logic [TOTAL_W-1:0] r_total, w_total_nx;
    logic [3:0]         r_player, w_player_nx;
    logic [1:0]         r_status, w_status_nx;
    logic [ERR_W-1:0]   r_err_cnt, w_err_nx;

    logic [TOTAL_W-1:0] w_take_ext;
    logic [TOTAL_W-1:0] w_diff;
    logic               w_valid;

    assign w_take_ext = TOTAL_W'(r_take);
    assign w_diff     = r_total - w_take_ext;
    assign w_valid    = (r_take != 4'd0) && (r_take <= MAX_T) && (w_take_ext <= r_total);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_take    <= 4'd0;
            r_total   <= TOTAL_W'(START_TOTAL);
            r_player  <= P1;
            r_status  <= STAT_NORMAL;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_take    <= w_take_nx;
            r_total   <= w_total_nx;
            r_player  <= w_player_nx;
            r_status  <= w_status_nx;
            r_err_cnt <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_take_nx   = r_take;
        w_total_nx  = r_total;
        w_player_nx = r_player;
        w_status_nx = r_status;
        w_err_nx    = r_err_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_mv_edge) begin
                    w_take_nx  = i_take;
                    w_state_nx = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_valid) begin
                    w_state_nx = ST_COMMIT;
                end else begin
                    w_state_nx  = ST_ERROR;
                    w_err_nx    = ERR_W'(ERR_HOLD);
                    w_status_nx = STAT_INVALID;
                end
            end
            ST_COMMIT: begin
                w_total_nx = w_diff;
                if (w_diff == '0) begin
                    w_status_nx = STAT_OVER;
                    w_state_nx  = ST_OVER;
                end else begin
                    w_player_nx = (r_player == P1) ? P2 : P1;
                    w_state_nx  = ST_WAIT_REL;
                end
            end
            ST_ERROR: begin
                if (r_err_cnt != '0) begin
                    w_err_nx = r_err_cnt - ERR_W'(1);
                end else if (!w_lvl[0]) begin
                    w_status_nx = STAT_NORMAL;
                    w_state_nx  = ST_IDLE;
                end
            end
            ST_WAIT_REL: begin
                if (w_lvl == 2'b00)
                    w_state_nx = ST_IDLE;
            end
            ST_OVER: begin
                w_state_nx = ST_OVER;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        // Restart overrides whatever the FSM decided this cycle, including a commit.
        if (w_rs_edge) begin
            w_total_nx  = TOTAL_W'(START_TOTAL);
            w_player_nx = P1;
            w_status_nx = STAT_NORMAL;
            w_err_nx    = '0;
            w_state_nx  = ST_WAIT_REL;
        end
    end

    assign o_total       = r_total;
    assign o_player_id   = r_player;
    assign o_status      = r_status;
    assign o_move_strobe = (r_state == ST_COMMIT) && !w_rs_edge;

endmodule

// File: tb/tb_match_turn_controller.sv
// Directed bench for match_turn_controller: moves, invalid moves, game over,
// bounce rejection, restart priority and reset abort.
module tb_match_turn_controller;

    logic       clk;
    logic       rst;
    logic [1:0] btn_n;
    logic [3:0] take;
    logic [6:0] total;
    logic [3:0] player_id;
    logic [1:0] status;
    logic       move_strobe;

    int vectors = 0;
    int errors  = 0;
    int strobes = 0;
    int s0;
    int n;
    int cnt;

    match_turn_controller dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_btn_n       (btn_n),
        .i_take        (take),
        .o_total       (total),
        .o_player_id   (player_id),
        .o_status      (status),
        .o_move_strobe (move_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (move_strobe) strobes++;

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_move(input int t);
        take = 4'(t);
        btn_n[0] = 1'b0;
        tick(14);
        btn_n[0] = 1'b1;
        tick(12);
    endtask

    task automatic wait_strobe(output int k);
        k = 99;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (move_strobe) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; btn_n = 2'b11; take = 4'd0;
        tick(3);
        chk("reset_total", total, 100);
        chk("reset_player", player_id, 1);
        chk("reset_status", status, 0);
        chk("reset_strobe", move_strobe, 0);
        rst = 1'b0;
        tick(10);

        // first move: latency, single commit while held
        take = 4'd7;
        btn_n[0] = 1'b0;
        wait_strobe(n);
        chk("move_latency", n, 8);
        tick(30);
        chk("held_one_commit", strobes, 1);
        chk("move_total", total, 93);
        chk("move_player", player_id, 2);
        chk("move_status", status, 0);
        btn_n[0] = 1'b1;
        tick(12);

        // take = 0, long hold
        take = 4'd0;
        btn_n[0] = 1'b0;
        tick(30);
        chk("zero_status", status, 1);
        chk("zero_total", total, 93);
        chk("zero_player", player_id, 2);
        btn_n[0] = 1'b1;
        tick(3);
        chk("zero_status_until_rel", status, 1);
        tick(10);
        chk("zero_status_clear", status, 0);

        // take = 11, short tap: invalid shown for exactly ERR_HOLD+1 cycles
        take = 4'd11;
        btn_n[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 8) btn_n[0] = 1'b1;
            tick(1);
            if (status == 2'b01) cnt++;
        end
        chk("eleven_hold_cycles", cnt, 9);
        chk("eleven_status_clear", status, 0);
        chk("eleven_total", total, 93);
        chk("errors_no_strobe", strobes, 1);

        // drain to 5 sticks
        for (int i = 0; i < 8; i++) do_move(10);
        do_move(8);
        chk("drain_total", total, 5);
        chk("drain_player", player_id, 1);

        // take exceeds remaining
        take = 4'd6;
        btn_n[0] = 1'b0;
        tick(10);
        chk("over_take_status", status, 1);
        btn_n[0] = 1'b1;
        tick(14);
        chk("over_take_clear", status, 0);
        chk("over_take_total", total, 5);

        // last sticks
        s0 = strobes;
        do_move(5);
        chk("last_strobe", strobes, s0 + 1);
        chk("last_total", total, 0);
        chk("last_status", status, 2);
        chk("last_player", player_id, 1);
        do_move(3);
        chk("over_ignore_strobe", strobes, s0 + 1);
        chk("over_ignore_total", total, 0);
        chk("over_ignore_status", status, 2);

        // restart from game over
        btn_n[1] = 1'b0;
        tick(10);
        chk("restart_total", total, 100);
        chk("restart_player", player_id, 1);
        chk("restart_status", status, 0);
        btn_n[1] = 1'b1;
        tick(12);

        // bounce: toggles every 2 cycles for 20 cycles, then stable low
        s0 = strobes;
        take = 4'd4;
        for (int i = 0; i < 10; i++) begin
            btn_n[0] = (i % 2 == 1);
            tick(2);
        end
        btn_n[0] = 1'b0;
        tick(20);
        btn_n[0] = 1'b1;
        tick(12);
        chk("bounce_one_strobe", strobes, s0 + 1);
        chk("bounce_total", total, 96);
        chk("bounce_player", player_id, 2);

        // restart and move edges in the same cycle
        s0 = strobes;
        take = 4'd3;
        btn_n = 2'b00;
        tick(12);
        chk("simul_no_strobe", strobes, s0);
        chk("simul_total", total, 100);
        chk("simul_player", player_id, 1);
        chk("simul_status", status, 0);
        btn_n = 2'b11;
        tick(12);

        // restart during ERROR
        do_move(3);
        chk("pre_err_total", total, 97);
        s0 = strobes;
        take = 4'd0;
        btn_n[0] = 1'b0;
        tick(10);
        chk("err_status", status, 1);
        btn_n[1] = 1'b0;
        tick(10);
        chk("err_restart_status", status, 0);
        chk("err_restart_total", total, 100);
        chk("err_restart_player", player_id, 1);
        chk("err_restart_no_strobe", strobes, s0);
        btn_n = 2'b11;
        tick(12);

        // reset during COMMIT, then held button must not re-trigger
        take = 4'd2;
        btn_n[0] = 1'b0;
        wait_strobe(n);
        chk("commit_seen", n, 8);
        rst = 1'b1;
        tick(1);
        chk("rst_commit_total", total, 100);
        chk("rst_commit_player", player_id, 1);
        chk("rst_commit_status", status, 0);
        chk("rst_commit_strobe", move_strobe, 0);
        s0 = strobes;
        tick(1);
        rst = 1'b0;
        tick(20);
        chk("held_after_rst_no_strobe", strobes, s0);
        chk("held_after_rst_total", total, 100);
        btn_n[0] = 1'b1;
        tick(12);
        do_move(2);
        chk("repress_strobe", strobes, s0 + 1);
        chk("repress_total", total, 98);
        chk("repress_player", player_id, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/match_turn_controller.md
Name: match_turn_controller

Overview:
- Sequences the match-stick game: debounces the two pushbuttons, validates each move from the dip switches, updates the remaining-stick total, alternates players and arbitrates the display status (normal / invalid / game over).
- Sits between the raw board inputs and the BCD converter / seven-segment driver.
- Replaces the ad-hoc press/release state logic with a single owned FSM.

Parameters:
- START_TOTAL, 100, stick count loaded at reset and restart.
- MAX_TAKE, 10, largest legal move.
- TOTAL_W, 7, width of the total counter; must satisfy START_TOTAL < 2**TOTAL_W.
- DB_CYCLES, 4, consecutive stable samples required by the debouncer. Use 4 in simulation and a large value for the board.
- ERR_HOLD, 8, minimum cycles the invalid status is shown.

Ports:
- clk  in  1  system clock
- rst  in  1  reset (see Behaviour)
- btn_n  in  2  raw active-low pushbuttons; [0] = move, [1] = restart
- take  in  4  dip-switch move value
- total  out  TOTAL_W  remaining sticks
- player_id  out  4  current player, encoded 4'd1 or 4'd2 for direct digit display
- status  out  2  2'b00 normal, 2'b01 invalid, 2'b10 game over
- move_strobe  out  1  one-cycle pulse on each committed move

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - total = START_TOTAL
  - player_id = 1
  - status = 00
  - move_strobe = 0
  - FSM = IDLE
  - debouncers cleared to "released"
  - error counter = 0
- Reset asserted mid-move or mid-error aborts that operation with no commit.
- Debounce:
  - Each button passes through a 2-FF synchronizer, then a stable-count filter.
  - The debounced level changes only after DB_CYCLES consecutive equal synchronized samples.
  - Press to debounced-level latency is 2 + DB_CYCLES cycles.
  - The controller acts on debounced rising edges only (press, i.e. btn_n going low).
- FSM states: IDLE, CHECK, COMMIT, ERROR, WAIT_REL, OVER.
  - IDLE: on a move edge, register take and go to CHECK.
  - CHECK (1 cycle): the move is valid iff 1 <= take <= MAX_TAKE and take <= total.
    - Valid -> COMMIT.
    - Invalid -> ERROR; load the error counter with ERR_HOLD and set status = 01.
  - COMMIT (1 cycle):
    - total <= total - take; move_strobe = 1.
    - If the new total is 0: status = 10, player_id unchanged (holds the player who took the last stick), go to OVER.
    - Otherwise toggle player_id between 1 and 2 and go to WAIT_REL.
    - Move-edge to strobe latency is 2 cycles.
  - ERROR: the error counter decrements to 0. Leave to IDLE only when the counter is 0 and the debounced move button is released; status returns to 00 on exit. total and player_id are unchanged.
  - WAIT_REL: return to IDLE when the debounced move button is released. No new move is accepted before that.
  - OVER: move edges are ignored; status stays 10.
- Restart edge, from any state including CHECK, COMMIT and ERROR:
  - total = START_TOTAL, player_id = 1, status = 00, error counter cleared, move_strobe = 0.
  - Go to WAIT_REL, which waits on both buttons released.
  - Restart has priority over a simultaneous move edge or commit; the move is discarded.
- Arithmetic: take is zero-extended to TOTAL_W. Subtraction cannot underflow because of the CHECK rule. The total never wraps.
- take is sampled only on entry to CHECK; later switch changes have no effect on that move.

Decomposition:
- Shared package match_pkg holds:
  - the status encodings STAT_NORMAL, STAT_INVALID, STAT_OVER;
  - the FSM state typedef;
  - the player encodings P1 = 4'd1, P2 = 4'd2.
- One sub-module, btn_debounce (parameter DB_CYCLES), instantiated twice. It holds the synchronizer and stable counter and outputs the level only.
- Edge detection stays in the controller.

Test Plan:
- Reset, then press move with take = 7, held well past debounce -> one move_strobe; total 100 -> 93; player_id 1 -> 2; no second commit while held.
- take = 0, then take = 11, each pressed -> status = 01 for at least 8 cycles; total and player_id unchanged; status returns to 00 only after release.
- total = 5 and take = 6 -> invalid. Then take = 5 -> total = 0, status = 10, player_id frozen at the mover; further move presses ignored.
- Button bounce (toggles every 2 cycles for 20 cycles, then stable low) -> exactly one commit.
- Restart pressed the same cycle as a move edge, and again during ERROR -> total = 100, player_id = 1, status = 00, no move_strobe.
- rst asserted during COMMIT -> next cycle all outputs at reset values; after rst is released, a held button does not generate an edge until it has been released and pressed again.
